// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: state encoding, phase-timer sizing and init-sequence constants for rtc_bus_master
package rtc_bus_pkg;
  typedef enum logic [3:0] {IDLE, A_SET, A_PUL, A_HLD, GAP, D_SET, D_PUL, D_HLD, DONE} state_t;
  localparam int INIT_LEN = 2;
  localparam logic [3:0][7:0] INIT_ADDR = {8'h00, 8'h10, 8'h02, 8'h02};
  localparam logic [3:0][7:0] INIT_DATA = {8'h00, 8'hD2, 8'h00, 8'h10};
  function automatic int tmr_w(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/rtc_bus_master_timer.sv
// rtc_phase_timer: loadable down-counter shared by all bus phases
// Ports: clk, rst_n (async, active-low), load + load_m1 (start a phase of load_m1+1 clks),
//        last (high on the final clock of the current phase)
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_m1,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == '0;
  always_comb cnt_d = load ? load_m1 : (last ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: single/burst master for the RTC multiplexed address/data bus
// Ports: clk, Reset_n (async, active-low); request side req/req_wr/req_addr/req_len,
//        wr_data/wr_next, rd_data/rd_valid, busy, done; pin side ChipSelect/Read/Write
//        (active-low), AoD (0 address, 1 data), ad_out/ad_oe/ad_in.
// Build option: RTC_INIT_SEQ_EN runs the RTC clear/init write sequence after reset.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              req,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [CNT_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_next,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              ChipSelect,
  output logic              Read,
  output logic              Write,
  output logic              AoD,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);
  localparam int TW = tmr_w(T_SETUP, T_PULSE, T_HOLD, T_GAP);
`ifdef RTC_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic wr_q, wr_d, init_q, init_d, aod_q, aod_d, cs_q, cs_d, rds_q, rds_d, wrs_q, wrs_d, oe_q, oe_d;
  logic wr_next_q, wr_next_d, rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] addr_q, addr_d, word_q, word_d, ad_q, ad_d, rd_data_q, rd_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic last, a_ph, d_ph;
  logic [TW-1:0] tval;
  rtc_phase_timer #(.W(TW)) u_tmr (
    .clk(clk), .rst_n(Reset_n), .load(state_d != state_q), .load_m1(tval), .last(last)
  );
  // AoD flips on entry to GAP so it is settled before ChipSelect falls again.
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    init_d = init_q;
    aod_d = aod_q;
    addr_d = addr_q;
    word_d = word_q;
    cnt_d = cnt_q;
    len_d = len_q;
    wr_next_d = 1'b0;
    case (state_q)
      IDLE: if (init_q || req) begin
        state_d = A_SET;
        wr_d = init_q || req_wr;
        addr_d = req_addr;
        len_d = init_q ? CNT_W'(INIT_LEN) : req_len;
        cnt_d = '0;
      end
      A_SET: if (last) state_d = A_PUL;
      A_PUL: if (last) state_d = A_HLD;
      A_HLD: if (last) begin
        state_d = GAP;
        aod_d = 1'b1;
      end
      D_SET: if (last) state_d = D_PUL;
      D_PUL: if (last) state_d = D_HLD;
      D_HLD: if (last) begin
        state_d = GAP;
        aod_d = 1'b0;
      end
      GAP: if (last) begin
        if (aod_q) begin
          state_d = D_SET;
          word_d = init_q ? DATA_W'(INIT_DATA[cnt_q[1:0]]) : wr_data;
          wr_next_d = wr_q && !init_q;
        end else if (cnt_q == len_q) begin
          state_d = init_q ? IDLE : DONE;
          init_d = 1'b0;
        end else begin
          state_d = A_SET;
          cnt_d = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    a_ph = state_d inside {A_SET, A_PUL, A_HLD};
    d_ph = state_d inside {D_SET, D_PUL, D_HLD};
    tval = (state_d == A_SET || state_d == D_SET) ? TW'(T_SETUP - 1) :
           (state_d == A_PUL || state_d == D_PUL) ? TW'(T_PULSE - 1) :
           (state_d == A_HLD || state_d == D_HLD) ? TW'(T_HOLD - 1) : TW'(T_GAP - 1);
    cs_d = !(a_ph || d_ph);
    rds_d = !(state_d == D_PUL && !wr_d);
    wrs_d = !(state_d == A_PUL || (state_d == D_PUL && wr_d));
    oe_d = a_ph || (d_ph && wr_d);
    ad_d = a_ph ? (init_q ? DATA_W'(INIT_ADDR[cnt_d[1:0]]) : addr_d) : (d_ph && wr_d) ? word_d : ad_q;
    rd_valid_d = state_q == D_PUL && last && !wr_q;
    rd_data_d = rd_valid_d ? ad_in : rd_data_q;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      init_q <= INIT_EN;
      aod_q <= 1'b0;
      cs_q <= 1'b1;
      rds_q <= 1'b1;
      wrs_q <= 1'b1;
      oe_q <= 1'b0;
      addr_q <= '0;
      word_q <= '0;
      ad_q <= '0;
      rd_data_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      wr_next_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q <= INIT_EN;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      init_q <= init_d;
      aod_q <= aod_d;
      cs_q <= cs_d;
      rds_q <= rds_d;
      wrs_q <= wrs_d;
      oe_q <= oe_d;
      addr_q <= addr_d;
      word_q <= word_d;
      ad_q <= ad_d;
      rd_data_q <= rd_data_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      wr_next_q <= wr_next_d;
      rd_valid_q <= rd_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ChipSelect = cs_q;
  assign Read = rds_q;
  assign Write = wrs_q;
  assign AoD = aod_q;
  assign ad_oe = oe_q;
  assign ad_out = ad_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_next = wr_next_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: scoreboard bench with a small RTC bus model
module tb_rtc_bus_master;
  localparam int T_PULSE = 4;
  localparam int WORD_T = 20;
`ifdef RTC_INIT_SEQ_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, req_wr = 1'b0;
  logic [7:0] req_addr = '0, wr_data, ad_in, rd_data, ad_out;
  logic [3:0] req_len = '0;
  logic wr_next, rd_valid, busy, done, ChipSelect, Read, Write, AoD, ad_oe;
  logic [7:0] mem [256];
  logic [7:0] wdat [16];
  logic [7:0] bus_addr = '0;
  logic [9:0] busq [$];
  logic [7:0] rdq [$];
  logic [9:0] e;
  logic [1:0] kind;
  logic str, p_str = 1'b0, p_cs = 1'b1, p_aod = 1'b0;
  bit aod_bad = 1'b0;
  int checks = 0, errors = 0, wi = 0, pw = 0, done_cnt = 0, wn_cnt = 0, rv_cnt = 0, cyc = 0, done_cyc = 0;
  rtc_bus_master dut (
    .clk(clk), .Reset_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .ChipSelect(ChipSelect), .Read(Read), .Write(Write), .AoD(AoD), .ad_out(ad_out),
    .ad_oe(ad_oe), .ad_in(ad_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign wr_data = wdat[wi[3:0]];
  assign ad_in = Read ? 8'h00 : mem[bus_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // RTC model and scoreboard: each strobe start pops one expected phase
  always @(negedge clk) begin
    if (!rst_n) begin
      pw = 0;
      p_str = 1'b0;
      p_cs = 1'b1;
      p_aod = 1'b0;
    end else begin
      str = !Read || !Write;
      if (str && !p_str) begin
        if (busq.size() == 0) chk("bus_extra", 1, 0);
        else begin
          e = busq.pop_front();
          kind = e[9:8];
          chk("phase", {AoD, ad_oe, ~Read, ~Write, (kind == 2'd2 ? 8'h00 : ad_out)},
              {kind != 2'd0, kind != 2'd2, kind == 2'd2, kind != 2'd2, e[7:0]});
          if (!Write) begin
            if (!AoD) bus_addr = ad_out;
            else mem[bus_addr] = ad_out;
          end
        end
      end
      if (str) pw++;
      if (!str && p_str) begin
        chk("pulse_w", pw, T_PULSE);
        pw = 0;
      end
      if (!ChipSelect && !p_cs && AoD != p_aod) aod_bad = 1'b1;
      if (rd_valid) begin
        rv_cnt++;
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_data", rd_data, rdq.pop_front());
      end
      if (wr_next) begin
        wn_cnt++;
        wi++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      p_str = str;
      p_cs = ChipSelect;
      p_aod = AoD;
    end
  end
  task automatic expect_txn(input bit wr, input logic [7:0] addr, input int len);
    logic [7:0] a;
    for (int k = 0; k <= len; k++) begin
      a = addr + 8'(k);
      busq.push_back({2'd0, a});
      if (wr) busq.push_back({2'd1, wdat[k]});
      else begin
        busq.push_back({2'd2, 8'h00});
        rdq.push_back(mem[a]);
      end
    end
    done_cnt = 0;
    wn_cnt = 0;
    rv_cnt = 0;
    wi = 0;
    aod_bad = 1'b0;
  endtask
  task automatic start(input bit wr, input logic [7:0] addr, input int len, output int c0);
    @(posedge clk);
    #1;
    req = 1'b1;
    req_wr = wr;
    req_addr = addr;
    req_len = 4'(len);
    c0 = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask
  task automatic run(input bit wr, input logic [7:0] addr, input int len, input bit poke);
    int c0;
    expect_txn(wr, addr, len);
    start(wr, addr, len, c0);
    if (poke) begin
      repeat (30) @(posedge clk);
      #1;
      req = 1'b1;
      req_wr = 1'b0;
      req_addr = 8'h99;
      repeat (2) @(posedge clk);
      #1;
      req = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    #1;
    chk("latency", done_cyc - c0, WORD_T * (len + 1) + 1);
    chk("busy_end", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("bus_left", busq.size(), 0);
    chk("rd_left", rdq.size(), 0);
    chk("wr_next_cnt", wn_cnt, wr ? len + 1 : 0);
    chk("rv_cnt", rv_cnt, wr ? 0 : len + 1);
    chk("aod_cs", aod_bad, 0);
  endtask
  task automatic release_rst();
    busq.delete();
    rdq.delete();
    done_cnt = 0;
    wi = 0;
`ifdef RTC_INIT_SEQ_EN
    busq = '{10'h002, 10'h110, 10'h002, 10'h100, 10'h010, 10'h1D2};
    req = 1'b1;
    req_wr = 1'b1;
    req_addr = 8'h55;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 500 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    chk("busy_rst", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rst", busy, 0);
    chk("init_left", busq.size(), 0);
    chk("init_done", done_cnt, 0);
`ifdef RTC_INIT_SEQ_EN
    chk("init_mem", {mem[8'h02], mem[8'h10]}, 16'h00D2);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) wdat[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {ChipSelect, Read, Write, AoD, ad_oe, rd_valid, wr_next, done, busy, ad_out, rd_data},
        {8'b11100000, INIT, 16'h0000});
    release_rst();
    wdat[0] = 8'h35;
    run(1'b1, 8'h21, 0, 1'b0);
    chk("mem_21", mem[8'h21], 8'h35);
    mem[8'h22] = 8'h47;
    run(1'b0, 8'h22, 0, 1'b0);
    mem[8'hFE] = 8'hA1;
    mem[8'hFF] = 8'hB2;
    mem[8'h00] = 8'hC3;
    run(1'b0, 8'hFE, 2, 1'b0);
    wdat[0] = 8'h11;
    wdat[1] = 8'h22;
    wdat[2] = 8'h33;
    wdat[3] = 8'h44;
    run(1'b1, 8'h40, 3, 1'b1);
    chk("mem_40", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h11223344);
    for (int i = 0; i < 16; i++) wdat[i] = 8'(i * 7 + 1);
    run(1'b1, 8'h80, 15, 1'b0);
    chk("mem_8f", {mem[8'h80], mem[8'h8F]}, 16'h016A);
    for (int i = 0; i < 4; i++) mem[8'h30 + i] = 8'h90 + 8'(i);
    expect_txn(1'b0, 8'h30, 3);
    start(1'b0, 8'h30, 3, c0);
    for (int i = 0; i < 200 && Read; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_pins", {ChipSelect, Read, Write, ad_oe, AoD}, 5'b11100);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_rv", rv_cnt, 0);
    chk("abort_done", done_cnt, 0);
    release_rst();
    run(1'b0, 8'h22, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
